// File: rtl/we_seq_pkg.sv
// Shared types and constants for the write-enable sequence controller.
package we_seq_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int RUN_W_DEF = 16;

  localparam logic [2:0] DBG_IDLE      = 3'd0;
  localparam logic [2:0] DBG_CFG_WAIT  = 3'd1;
  localparam logic [2:0] DBG_TASK_WAIT = 3'd2;
  localparam logic [2:0] DBG_GAP       = 3'd3;
  localparam logic [2:0] DBG_DONE      = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = DBG_IDLE,
    S_CFG_WAIT  = DBG_CFG_WAIT,
    S_TASK_WAIT = DBG_TASK_WAIT,
    S_GAP       = DBG_GAP,
    S_DONE      = DBG_DONE
  } state_e;

endpackage

// File: rtl/we_edge_det.sv
// Rising-edge detector: registered history, edge flagged in the cycle the input rises.
module we_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/we_seq_ctrl.sv
// Sequencer: optional SPI config, then n task runs separated by idle gaps.
// Optional watchdog on the wait states is enabled with `define WE_SEQ_TIMEOUT_EN.
module we_seq_ctrl
  import we_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int RUN_W = RUN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             skip_config,
  input  logic [RUN_W-1:0] n_runs,
  input  logic [CNT_W-1:0] gap_cycles,
  input  logic [CNT_W-1:0] timeout_cycles,
  input  logic             done_spi,
  input  logic             done_task,
  output logic             trigger_config,
  output logic             trigger_task,
  output logic             busy,
  output logic [RUN_W-1:0] run_idx,
  output logic             seq_done,
  output logic             err_timeout,
  output logic [2:0]       state_dbg
);

  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state;
  logic [RUN_W-1:0] n_lat;
  logic [CNT_W-1:0] gap_lat;
  logic [CNT_W-1:0] gap_cnt;
  logic             spi_rise;
  logic             task_rise;
  logic             wd_hit;
  logic [RUN_W-1:0] n_eff;
  logic [RUN_W-1:0] run_next;

  we_edge_det u_edge_spi  (.clk(clk), .rst_n(rst_n), .d(done_spi),  .rise(spi_rise));
  we_edge_det u_edge_task (.clk(clk), .rst_n(rst_n), .d(done_task), .rise(task_rise));

  assign n_eff    = (n_runs == '0) ? RUN_ONE : n_runs;
  assign run_next = run_idx + RUN_ONE;

`ifdef WE_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_lat;
  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] wd_age;
  logic             err_q;
  logic             in_wait;

  // A trigger marks the entry cycle of a wait state, so the age restarts there.
  assign in_wait = (state == S_CFG_WAIT) || (state == S_TASK_WAIT);
  assign wd_age  = (trigger_config || trigger_task) ? '0 : wd_cnt;
  assign wd_hit  = in_wait && (tmo_lat != '0) && (wd_age == tmo_lat - CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_cnt <= '0;
    else if (in_wait) wd_cnt <= wd_age + CNT_ONE;
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles;
  assign wd_hit         = 1'b0;
  assign err_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      n_lat          <= '0;
      gap_lat        <= '0;
      gap_cnt        <= '0;
      run_idx        <= '0;
      trigger_config <= 1'b0;
      trigger_task   <= 1'b0;
      seq_done       <= 1'b0;
`ifdef WE_SEQ_TIMEOUT_EN
      tmo_lat        <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      trigger_config <= 1'b0;
      trigger_task   <= 1'b0;
      seq_done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            n_lat   <= n_eff;
            gap_lat <= gap_cycles;
            run_idx <= '0;
`ifdef WE_SEQ_TIMEOUT_EN
            tmo_lat <= timeout_cycles;
            err_q   <= 1'b0;
`endif
            if (skip_config) begin
              state        <= S_TASK_WAIT;
              trigger_task <= 1'b1;
            end else begin
              state          <= S_CFG_WAIT;
              trigger_config <= 1'b1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          // Abort outranks every other event in the active states.
          if (abort) begin
            state <= S_IDLE;
          end else if (state == S_CFG_WAIT) begin
            if (spi_rise) begin
              state        <= S_TASK_WAIT;
              trigger_task <= 1'b1;
            end else if (wd_hit) begin
              state <= S_IDLE;
`ifdef WE_SEQ_TIMEOUT_EN
              err_q <= 1'b1;
`endif
            end
          end else if (state == S_TASK_WAIT) begin
            if (task_rise) begin
              run_idx <= run_next;
              if (run_next == n_lat) begin
                state    <= S_DONE;
                seq_done <= 1'b1;
              end else if (gap_lat == '0) begin
                trigger_task <= 1'b1;
              end else begin
                state   <= S_GAP;
                gap_cnt <= '0;
              end
            end else if (wd_hit) begin
              state <= S_IDLE;
`ifdef WE_SEQ_TIMEOUT_EN
              err_q <= 1'b1;
`endif
            end
          end else begin
            if (gap_cnt == gap_lat - CNT_ONE) begin
              state        <= S_TASK_WAIT;
              trigger_task <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + CNT_ONE;
            end
          end
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_we_seq_ctrl.sv
// Bench for we_seq_ctrl: cycle model checked every cycle plus directed literal checks.
// Timeout scenario depends on `define WE_SEQ_TIMEOUT_EN.
module tb_we_seq_ctrl;

  localparam int CNT_W = 32;
  localparam int RUN_W = 16;
`ifdef WE_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0, abort = 1'b0, skip_config = 1'b0;
  logic             done_spi = 1'b0, done_task = 1'b0;
  logic [RUN_W-1:0] n_runs = '0;
  logic [CNT_W-1:0] gap_cycles = '0, timeout_cycles = '0;
  logic             trigger_config, trigger_task, busy, seq_done, err_timeout;
  logic [RUN_W-1:0] run_idx;
  logic [2:0]       state_dbg;

  we_seq_ctrl #(.CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .skip_config(skip_config),
    .n_runs(n_runs), .gap_cycles(gap_cycles), .timeout_cycles(timeout_cycles),
    .done_spi(done_spi), .done_task(done_task), .trigger_config(trigger_config),
    .trigger_task(trigger_task), .busy(busy), .run_idx(run_idx), .seq_done(seq_done),
    .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: phase numbers are the documented state codes.
  int m_phase = 0, m_runs = 0, m_target = 0, m_gap = 0, m_tmo = 0, m_gap_left = 0, m_age = 0;
  bit m_err = 0, m_tc = 0, m_tt = 0, m_sd = 0, m_p_spi = 0, m_p_task = 0;
  wire m_spi_rise  = done_spi && !m_p_spi;
  wire m_task_rise = done_task && !m_p_task;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_runs <= 0; m_target <= 0; m_gap <= 0; m_tmo <= 0;
      m_gap_left <= 0; m_age <= 0; m_err <= 0; m_tc <= 0; m_tt <= 0; m_sd <= 0;
      m_p_spi <= 0; m_p_task <= 0;
    end else begin
      m_p_spi <= done_spi; m_p_task <= done_task;
      m_tc <= 0; m_tt <= 0; m_sd <= 0;
      if (m_phase == 0) begin
        if (start && !abort) begin
          m_target <= (n_runs == 0) ? 1 : int'(n_runs);
          m_gap    <= int'(gap_cycles);
          m_tmo    <= TMO_EN ? int'(timeout_cycles) : 0;
          m_runs   <= 0; m_err <= 0; m_age <= 0;
          if (skip_config) begin m_phase <= 2; m_tt <= 1; end
          else begin m_phase <= 1; m_tc <= 1; end
        end
      end else if (m_phase == 4 || abort) begin
        m_phase <= 0;
      end else if (m_phase == 3) begin
        if (m_gap_left == 1) begin m_phase <= 2; m_tt <= 1; m_age <= 0; end
        else m_gap_left <= m_gap_left - 1;
      end else if (m_phase == 1 && m_spi_rise) begin
        m_phase <= 2; m_tt <= 1; m_age <= 0;
      end else if (m_phase == 2 && m_task_rise) begin
        m_runs <= m_runs + 1;
        if (m_runs + 1 == m_target) begin m_phase <= 4; m_sd <= 1; end
        else if (m_gap == 0) begin m_tt <= 1; m_age <= 0; end
        else begin m_phase <= 3; m_gap_left <= m_gap; end
      end else if (m_tmo != 0 && m_age + 1 >= m_tmo) begin
        m_err <= 1; m_phase <= 0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  // scoreboard
  int total = 0, bad = 0;
  int n_tc = 0, n_tt = 0, n_sd = 0;
  int tc_cyc = 0, tt_cyc = 0, err_cyc = -1, raise_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every wait goes through here so the model comparison runs each cycle.
  task automatic tick();
    @(negedge clk);
    check("state_dbg", int'(state_dbg), m_phase);
    check("busy", int'(busy), int'(m_phase != 0));
    check("trigger_config", int'(trigger_config), int'(m_tc));
    check("trigger_task", int'(trigger_task), int'(m_tt));
    check("seq_done", int'(seq_done), int'(m_sd));
    check("run_idx", int'(run_idx), m_runs);
    check("err_timeout", int'(err_timeout), int'(m_err));
    check("one_trigger", int'(trigger_config & trigger_task), 0);
    if (trigger_config) begin n_tc++; tc_cyc = cyc; end
    if (trigger_task) begin n_tt++; tt_cyc = cyc; end
    if (seq_done) n_sd++;
    if (err_timeout && err_cyc < 0) err_cyc = cyc;
  endtask

  // driver tasks
  task automatic setup(input int n, input int gap, input bit skip, input int tmo);
    n_runs = RUN_W'(n); gap_cycles = CNT_W'(gap); skip_config = skip; timeout_cycles = CNT_W'(tmo);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_trig(input bit want_cfg, input string name);
    int k = 0;
    while (!(want_cfg ? trigger_config : trigger_task) && k < 300) begin tick(); k++; end
    check(name, int'(k < 300), 1);
  endtask

  task automatic respond_task(input int delay);
    repeat (delay) tick();
    done_task = 1'b1; raise_cyc = cyc; tick(); done_task = 1'b0;
  endtask

  initial begin
    int b_tc, b_tt, b_sd;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("reset_state", int'(state_dbg), 0);
    check("reset_run_idx", int'(run_idx), 0);
    rst_n = 1'b1; tick();

    // three runs with config and 5-cycle gaps; a stray start mid-sequence is ignored
    setup(3, 5, 0, 0); b_tc = n_tc; b_tt = n_tt; b_sd = n_sd;
    pulse_start();
    wait_trig(1, "cfg_trig_seen");
    repeat (10) tick();
    done_spi = 1'b1; tick(); done_spi = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wait_trig(0, "task_trig_seen");
      if (r > 0) check("gap5_spacing", tt_cyc - raise_cyc, 6);
      respond_task(10);
      if (r == 0) pulse_start();
    end
    repeat (4) tick();
    check("s1_cfg_trigs", n_tc - b_tc, 1);
    check("s1_task_trigs", n_tt - b_tt, 3);
    check("s1_seq_done", n_sd - b_sd, 1);
    check("s1_run_idx", int'(run_idx), 3);

    // skip_config with n_runs=0 behaves as one run
    setup(0, 5, 1, 0); b_tc = n_tc; b_tt = n_tt; b_sd = n_sd;
    pulse_start();
    wait_trig(0, "s2_trig_seen");
    respond_task(3);
    repeat (4) tick();
    check("s2_cfg_trigs", n_tc - b_tc, 0);
    check("s2_task_trigs", n_tt - b_tt, 1);
    check("s2_seq_done", n_sd - b_sd, 1);
    check("s2_run_idx", int'(run_idx), 1);

    // zero gap re-triggers in the cycle after the done edge
    setup(2, 0, 1, 0); b_sd = n_sd;
    pulse_start();
    wait_trig(0, "s3_trig_seen");
    respond_task(2);
    wait_trig(0, "s3_trig2_seen");
    check("gap0_spacing", tt_cyc - raise_cyc, 1);
    respond_task(2);
    repeat (3) tick();
    check("s3_seq_done", n_sd - b_sd, 1);
    check("s3_run_idx", int'(run_idx), 2);

    // done_task held high counts once
    setup(2, 2, 1, 0); b_tt = n_tt; b_sd = n_sd;
    pulse_start();
    wait_trig(0, "s4_trig_seen");
    repeat (3) tick();
    done_task = 1'b1;
    repeat (50) tick();
    check("held_state", int'(state_dbg), 2);
    check("held_run_idx", int'(run_idx), 1);
    check("held_task_trigs", n_tt - b_tt, 2);
    check("held_seq_done", n_sd - b_sd, 0);
    done_task = 1'b0; tick();
    respond_task(1);
    repeat (3) tick();
    check("s4_seq_done", n_sd - b_sd, 1);
    check("s4_run_idx", int'(run_idx), 2);

    // abort coincident with a done edge in run 2 of 4
    setup(4, 3, 1, 0); b_tt = n_tt; b_sd = n_sd;
    pulse_start();
    wait_trig(0, "s5_trig_seen");
    respond_task(2);
    wait_trig(0, "s5_trig2_seen");
    repeat (2) tick();
    done_task = 1'b1; abort = 1'b1; tick(); done_task = 1'b0; abort = 1'b0;
    check("abort_state", int'(state_dbg), 0);
    check("abort_run_idx", int'(run_idx), 1);
    repeat (30) tick();
    check("abort_task_trigs", n_tt - b_tt, 2);
    check("abort_seq_done", n_sd - b_sd, 0);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("start_abort_idle", int'(busy), 0);
    check("idle_holds_run_idx", int'(run_idx), 1);

    // watchdog
`ifdef WE_SEQ_TIMEOUT_EN
    setup(1, 0, 0, 100); err_cyc = -1;
    pulse_start();
    wait_trig(1, "s6_cfg_seen");
    for (int k = 0; k < 150 && !err_timeout; k++) tick();
    check("timeout_latency", err_cyc - tc_cyc, 100);
    check("timeout_busy", int'(busy), 0);
    check("timeout_flag", int'(err_timeout), 1);
    pulse_start();
    check("timeout_cleared", int'(err_timeout), 0);
    abort = 1'b1; tick(); abort = 1'b0;
`else
    setup(1, 0, 0, 5);
    pulse_start();
    repeat (20) tick();
    check("no_wd_state", int'(state_dbg), 1);
    check("no_wd_err", int'(err_timeout), 0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("no_wd_abort", int'(state_dbg), 0);
`endif

    // reset in GAP, then a fresh sequence
    setup(3, 20, 1, 0);
    pulse_start();
    wait_trig(0, "s7_trig_seen");
    respond_task(2);
    repeat (3) tick();
    check("gap_before_reset", int'(state_dbg), 3);
    rst_n = 1'b0; tick();
    check("rst_state", int'(state_dbg), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_run_idx", int'(run_idx), 0);
    check("rst_triggers", int'(trigger_config | trigger_task | seq_done), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    b_tc = n_tc; b_tt = n_tt; b_sd = n_sd;
    repeat (30) tick();
    check("post_rst_pulses", (n_tc - b_tc) + (n_tt - b_tt) + (n_sd - b_sd), 0);
    setup(1, 0, 0, 0);
    pulse_start();
    wait_trig(1, "s8_cfg_seen");
    repeat (4) tick();
    done_spi = 1'b1; tick(); done_spi = 1'b0;
    wait_trig(0, "s8_trig_seen");
    respond_task(5);
    repeat (3) tick();
    check("fresh_seq_done", n_sd - b_sd, 1);
    check("fresh_run_idx", int'(run_idx), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

endmodule
